serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor: one bit per clock, LSB first, WIDTH clocks per operation.
// Results (difference, borrow, signed overflow) are registered and held until the next completion.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             bw;
  logic             d_bit;
  logic             bw_next;
  logic             last_bit;
  logic [WIDTH-1:0] diff_final;

  // Full-subtractor cell on the current LSBs.
  assign d_bit      = a_sr[0] ^ b_sr[0] ^ bw;
  assign bw_next    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bw);
  assign last_bit   = (cnt == CW'(WIDTH - 1));
  assign diff_final = {d_bit, res_sr[WIDTH-1:1]};
  assign o_busy     = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt      <= '0;
      bw       <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      o_done   <= 1'b0;
      o_diff   <= '0;
      o_borrow <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            a_sr <= i_a;
            b_sr <= i_b;
            bw   <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= diff_final;
          bw     <= bw_next;
          cnt    <= cnt + CW'(1);
          // On the last bit a_sr[0]/b_sr[0] hold the operand sign bits.
          if (last_bit) begin
            o_diff   <= diff_final;
            o_borrow <= bw_next;
            o_ovf    <= (a_sr[0] != b_sr[0]) && (d_bit != a_sr[0]);
            o_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
